uart_rx_drain: RTL and testbench

Receive-side drain stage that sits directly downstream of the UART receiver. It tracks the receiver's ring-buffer write index, keeps its own read index and occupancy count, and presents received bytes in order on a valid/ready byte stream for the CPU-side bus logic. It also detects receiver overrun (a write into a full ring) and reports it through a sticky flag.

---
 rtl/uart_rx_drain.sv | 58 +++++
 tb/tb_uart_rx_drain.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_drain.sv
// uart_rx_drain: drains the UART receive ring onto a valid/ready byte stream with sticky overrun detect
module uart_rx_drain #(
  parameter int BufferSize = 64,
  parameter int IdxW       = $clog2(BufferSize)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IdxW-1:0] rx_wr_idx,
  input  logic [7:0]      read_buffer [BufferSize],
  output logic [7:0]      m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [IdxW:0]   count,
  output logic            overrun,
  input  logic            overrun_clr,
  input  logic            flush
);
  localparam logic [IdxW:0] Full = (IdxW+1)'(BufferSize);
  logic [IdxW-1:0] wr_idx_q, rd_idx_q, rd_idx_d;
  logic [IdxW:0]   count_q, count_d;
  logic [7:0]      m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d, overrun_q, overrun_d;
  logic            wr_event, load, ovr;
  always_comb begin
    wr_event  = rx_wr_idx != wr_idx_q;
    load      = (count_q != '0) && (!m_valid_q || m_ready);
    ovr       = wr_event && !load && count_q == Full;
    // an overrun drops the oldest resident byte so the ring ends with the newest
    rd_idx_d  = flush ? rx_wr_idx : (load || ovr) ? rd_idx_q + IdxW'(1) : rd_idx_q;
    count_d   = flush ? '0 :
                (wr_event && !load && !ovr) ? count_q + (IdxW+1)'(1) :
                (load && !wr_event) ? count_q - (IdxW+1)'(1) : count_q;
    m_valid_d = flush ? 1'b0 : load ? 1'b1 : m_ready ? 1'b0 : m_valid_q;
    m_data_d  = (load && !flush) ? read_buffer[rd_idx_q] : m_data_q;
    overrun_d = (ovr && !flush) || (overrun_q && !overrun_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      count_q   <= '0;
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_idx_q  <= rx_wr_idx;
      rd_idx_q  <= rd_idx_d;
      count_q   <= count_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      overrun_q <= overrun_d;
    end
  end
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign count   = count_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_uart_rx_drain.sv
// tb_uart_rx_drain: directed scenarios on a 4-deep ring with hand-computed expectations
module tb_uart_rx_drain;
  logic       clk, rst_n, m_ready, overrun_clr, flush, m_valid, overrun;
  logic [1:0] rx_wr_idx, wi;
  logic [7:0] bufm [4];
  logic [7:0] m_data;
  logic [2:0] count;
  int n_checks, n_fail;
  uart_rx_drain #(.BufferSize(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_wr_idx(rx_wr_idx), .read_buffer(bufm),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
    .overrun(overrun), .overrun_clr(overrun_clr), .flush(flush)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] b);
    bufm[wi] = b;
    wi = wi + 2'd1;
    rx_wr_idx = wi;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    wi = 2'd0;
    rx_wr_idx = 2'd0;
    m_ready = 1'b0;
    overrun_clr = 1'b0;
    flush = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({m_valid, m_data, count, overrun} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h count=%0d ovr=%b, required all zero", m_valid, m_data, count, overrun);
    end
  endtask
  task automatic test_single();
    do_reset();
    wr(8'hA5);
    step();
    n_checks++;
    if (count !== 3'd1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_e1: count=%0d valid=%b, required 1/0", count, m_valid);
    end
    step();
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_e2: valid=%b data=%h count=%0d, required 1/a5/0", m_valid, m_data, count);
    end
    step();
    step();
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_hold: valid=%b data=%h, required 1/a5", m_valid, m_data);
    end
    m_ready = 1'b1;
    step();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: valid=%b, required 0", m_valid);
    end
  endtask
  task automatic test_burst_wrap();
    int k;
    k = 0;
    do_reset();
    m_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (j < 6) wr(8'(8'h10 + j));
      repeat (3) begin
        if (m_valid) begin
          n_checks++;
          if (m_data !== 8'(8'h10 + k)) begin
            n_fail++;
            $display("FAIL burst_byte%0d: got %h, required %h", k, m_data, 8'(8'h10 + k));
          end
          k++;
        end
        step();
      end
    end
    n_checks++;
    if (k !== 6 || overrun !== 1'b0 || dut.rd_idx_q !== 2'd2) begin
      n_fail++;
      $display("FAIL burst_end: bytes=%0d ovr=%b rd_idx=%0d, required 6/0/2", k, overrun, dut.rd_idx_q);
    end
  endtask
  task automatic test_overrun();
    logic [7:0] exp [5];
    int k;
    exp = '{8'h20, 8'h22, 8'h23, 8'h24, 8'h25};
    k = 0;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      wr(8'(8'h20 + j));
      step();
    end
    n_checks++;
    if (count !== 3'd4 || overrun !== 1'b0 || m_data !== 8'h20 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_full: count=%0d ovr=%b data=%h valid=%b, required 4/0/20/1", count, overrun, m_data, m_valid);
    end
    wr(8'h25);
    step();
    n_checks++;
    if (count !== 3'd4 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set: count=%0d ovr=%b, required 4/1", count, overrun);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 12 && k < 5; i++) begin
      if (m_valid) begin
        n_checks++;
        if (m_data !== exp[k]) begin
          n_fail++;
          $display("FAIL ovr_stream%0d: got %h, required %h", k, m_data, exp[k]);
        end
        k++;
      end
      step();
    end
    n_checks++;
    if (k !== 5 || m_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL ovr_drain: bytes=%0d valid=%b count=%0d, required 5/0/0", k, m_valid, count);
    end
  endtask
  task automatic test_full_accept();
    do_reset();
    for (int j = 0; j < 5; j++) begin
      wr(8'(8'h30 + j));
      step();
    end
    m_ready = 1'b1;
    wr(8'h35);
    step();
    n_checks++;
    if (count !== 3'd4 || overrun !== 1'b0 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_accept: count=%0d ovr=%b valid=%b, required 4/0/1", count, overrun, m_valid);
    end
  endtask
  task automatic test_flush();
    int k;
    k = 0;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      wr(8'(8'h40 + j));
      step();
    end
    n_checks++;
    if (count !== 3'd3 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre: count=%0d valid=%b, required 3/1", count, m_valid);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++;
    if (count !== 3'd0 || m_valid !== 1'b0 || dut.rd_idx_q !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_post: count=%0d valid=%b rd_idx=%0d, required 0/0/0", count, m_valid, dut.rd_idx_q);
    end
    wr(8'h4F);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (m_valid) begin
        n_checks++;
        if (m_data !== 8'h4F || k != 0) begin
          n_fail++;
          $display("FAIL flush_new%0d: got %h, required single 4f", k, m_data);
        end
        k++;
      end
      step();
    end
    n_checks++;
    if (k !== 1) begin
      n_fail++;
      $display("FAIL flush_count: bytes=%0d, required 1", k);
    end
  endtask
  task automatic test_overrun_clr();
    do_reset();
    for (int j = 0; j < 5; j++) begin
      wr(8'(8'h50 + j));
      step();
    end
    wr(8'h55);
    overrun_clr = 1'b1;
    step();
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_race: ovr=%b, required 1", overrun);
    end
    step();
    overrun_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_alone: ovr=%b, required 0", overrun);
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    for (int j = 0; j < 4; j++) begin
      wr(8'(8'h60 + j));
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || count !== 3'd0 || m_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b count=%0d data=%h, required 0/0/00", m_valid, count, m_data);
    end
    do_reset();
  endtask
  initial begin
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 4; i++) bufm[i] = 8'h00;
    test_reset();
    test_single();
    test_burst_wrap();
    test_overrun();
    test_full_accept();
    test_flush();
    test_overrun_clr();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
